// File: rtl/bomb_pkg.sv
// Shared state codes, valid user IDs and the level-time helper for the bomb game.
package bomb_pkg;

  typedef enum logic [7:0] {
    ST_IDLE       = 8'h00,
    ST_READY      = 8'h08,
    ST_PLAY       = 8'h10,
    ST_LEVEL_DONE = 8'h20,
    ST_GAME_OVER  = 8'h30
  } state_t;

  localparam logic [3:0] USER_ID_0 = 4'b1100;
  localparam logic [3:0] USER_ID_1 = 4'b0011;
  localparam logic [3:0] USER_ID_2 = 4'b1101;
  localparam logic [3:0] USER_ID_3 = 4'b0100;

  function automatic logic is_valid_user(input logic [3:0] id);
    return id inside {USER_ID_0, USER_ID_1, USER_ID_2, USER_ID_3};
  endfunction

  // Product kept at 16 bits so large stored levels clamp to the floor instead of wrapping.
  function automatic logic [7:0] load_time(input logic [7:0] lvl, input logic [7:0] base,
                                           input logic [7:0] step, input logic [7:0] min_t);
    logic [15:0] prod;
    logic [7:0]  diff;
    prod = 16'(lvl) * 16'(step);
    if (prod >= 16'(base)) return min_t;
    diff = 8'(16'(base) - prod);
    return (diff < min_t) ? min_t : diff;
  endfunction

endpackage

// File: rtl/bomb_tick_gen.sv
// Countdown-second divider: one-cycle tick every CLK_HZ cycles, restarted by clr.
module bomb_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_HZ + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset || clr || tick) count_reg <= '0;
    else                       count_reg <= count_reg + CW'(1);
  end

  assign tick = (count_reg == LAST) && !clr;

endmodule

// File: rtl/bomb_game_ctrl.sv
// Bomb game sequencer: login, per-level countdown, defuse/fail handling.
// Optional strike tolerance is built when BOMB_STRIKES_EN is defined.
module bomb_game_ctrl
  import bomb_pkg::*;
#(
  parameter int         CLK_HZ         = 50_000_000,
  parameter logic [7:0] BASE_TIME      = 8'd60,
  parameter logic [7:0] TIME_STEP      = 8'd5,
  parameter logic [7:0] MIN_TIME       = 8'd10,
  parameter logic [7:0] MAX_LEVEL      = 8'd9,
  parameter int         MAX_STRIKES    = 2,
  parameter logic [7:0] STRIKE_PENALTY = 8'd5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] user_sw,
  input  logic       login,
  input  logic       start,
  input  logic       defuse_ok,
  input  logic       defuse_fail,
  input  logic [7:0] cur_level,
  output logic [3:0] user_id,
  output logic [7:0] game_state,
  output logic [7:0] time_left,
  output logic [7:0] level,
  output logic       win
);

  state_t     state_reg, state_next;
  logic [3:0] user_reg, user_next;
  logic [7:0] time_reg, time_next;
  logic [7:0] level_reg, level_next;
  logic       win_reg, win_next;
  logic       tick;

`ifdef BOMB_STRIKES_EN
  localparam int SW = $clog2(MAX_STRIKES + 2);
  logic [SW-1:0] strikes_reg, strikes_next;
`else
  logic [8:0] unused_strike_cfg;
  assign unused_strike_cfg = {^32'(MAX_STRIKES), STRIKE_PENALTY};
`endif

  // Counter held cleared outside PLAY so every entry restarts a full second.
  bomb_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (state_reg != ST_PLAY),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      user_reg  <= '0;
      time_reg  <= '0;
      level_reg <= '0;
      win_reg   <= 1'b0;
`ifdef BOMB_STRIKES_EN
      strikes_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      user_reg  <= user_next;
      time_reg  <= time_next;
      level_reg <= level_next;
      win_reg   <= win_next;
`ifdef BOMB_STRIKES_EN
      strikes_reg <= strikes_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    user_next  = user_reg;
    time_next  = time_reg;
    level_next = level_reg;
    win_next   = win_reg;
`ifdef BOMB_STRIKES_EN
    strikes_next = strikes_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (login && is_valid_user(user_sw)) begin
          user_next  = user_sw;
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        if (start) begin
          time_next  = load_time(cur_level, BASE_TIME, TIME_STEP, MIN_TIME);
          state_next = ST_PLAY;
`ifdef BOMB_STRIKES_EN
          strikes_next = '0;
`endif
        end
      end
      ST_PLAY: begin
        if (defuse_ok) begin
          state_next = ST_LEVEL_DONE;
        end else if (defuse_fail) begin
`ifdef BOMB_STRIKES_EN
          if (strikes_reg == SW'(MAX_STRIKES)) begin
            state_next = ST_GAME_OVER;
          end else begin
            strikes_next = strikes_reg + SW'(1);
            time_next    = (time_reg > STRIKE_PENALTY) ? time_reg - STRIKE_PENALTY : 8'd0;
          end
`else
          state_next = ST_GAME_OVER;
`endif
        end else if (time_reg == 8'd0) begin
          state_next = ST_GAME_OVER;
        end else if (tick) begin
          time_next = time_reg - 8'd1;
        end
      end
      ST_LEVEL_DONE: begin
        level_next = level_reg + 8'd1;
        if (level_reg + 8'd1 == MAX_LEVEL) begin
          win_next   = 1'b1;
          state_next = ST_GAME_OVER;
        end else begin
          time_next  = load_time(cur_level, BASE_TIME, TIME_STEP, MIN_TIME);
          state_next = ST_PLAY;
`ifdef BOMB_STRIKES_EN
          strikes_next = '0;
`endif
        end
      end
      ST_GAME_OVER: begin
        if (start) begin
          state_next = ST_IDLE;
          user_next  = '0;
          level_next = '0;
          win_next   = 1'b0;
          time_next  = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign game_state = state_reg;
  assign user_id    = user_reg;
  assign time_left  = time_reg;
  assign level      = level_reg;
  assign win        = win_reg;

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// Bench for bomb_game_ctrl: directed vector table, multi-cycle sequences, random vs reference model.
module tb_bomb_game_ctrl;

  localparam int HZ = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] user_sw = '0;
  logic       login = 1'b0, start = 1'b0, defuse_ok = 1'b0, defuse_fail = 1'b0;
  logic [7:0] cur_level = '0;
  logic [3:0] user_id;
  logic [7:0] game_state, time_left, level;
  logic       win;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bomb_game_ctrl #(.CLK_HZ(HZ)) dut (
    .clk         (clk),
    .reset       (reset),
    .user_sw     (user_sw),
    .login       (login),
    .start       (start),
    .defuse_ok   (defuse_ok),
    .defuse_fail (defuse_fail),
    .cur_level   (cur_level),
    .user_id     (user_id),
    .game_state  (game_state),
    .time_left   (time_left),
    .level       (level),
    .win         (win)
  );

  typedef struct {
    string      name;
    logic       lg, st, ok, fl;
    logic [3:0] sw;
    logic [7:0] cl;
    int         es, et, el, eu, ew;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string name, input logic lg, st, ok, fl, input logic [3:0] sw,
                     input logic [7:0] cl, input int es, et, el, eu, ew);
    vec_t v;
    v.name = name; v.lg = lg; v.st = st; v.ok = ok; v.fl = fl; v.sw = sw; v.cl = cl;
    v.es = es; v.et = et; v.el = el; v.eu = eu; v.ew = ew;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input bit verbose, input int es, et, el, eu, ew);
    total++;
    if (game_state !== 8'(es) || time_left !== 8'(et) || level !== 8'(el) ||
        user_id !== 4'(eu) || win !== 1'(ew)) begin
      bad++;
      $display("FAIL %s @%0t: got state=%h time=%0d level=%0d user=%h win=%0d, want state=%h time=%0d level=%0d user=%h win=%0d",
               name, $time, game_state, time_left, level, user_id, win,
               8'(es), et, el, 4'(eu), ew);
    end else if (verbose) begin
      $display("ok   %s: state=%h time=%0d level=%0d user=%h win=%0d",
               name, game_state, time_left, level, user_id, win);
    end
  endtask

  // Apply one cycle of inputs, sample just after the edge, then drop the pulses.
  task automatic cyc(input logic lg, st, ok, fl, input logic [3:0] sw, input logic [7:0] cl);
    @(negedge clk);
    login = lg; start = st; defuse_ok = ok; defuse_fail = fl; user_sw = sw; cur_level = cl;
    @(posedge clk);
    #1;
    login = 1'b0; start = 1'b0; defuse_ok = 1'b0; defuse_fail = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    login = 1'b0; start = 1'b0; defuse_ok = 1'b0; defuse_fail = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset", 1'b1, 'h00, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Reference model: straight from the game rules, integer arithmetic.
  int m_st, m_time, m_level, m_uid, m_win, m_cnt;
`ifdef BOMB_STRIKES_EN
  int m_strk;
`endif

  function automatic int mload(input int cl);
    int t;
    t = 60 - cl * 5;
    return (t < 10) ? 10 : t;
  endfunction

  task automatic model_step(input bit rst_n, lg, st, ok, fl, input int sw, cl);
    bit tk;
    if (!rst_n) begin
      m_st = 0; m_time = 0; m_level = 0; m_uid = 0; m_win = 0; m_cnt = 0;
      return;
    end
    case (m_st)
      'h00: if (lg && (sw == 12 || sw == 3 || sw == 13 || sw == 4)) begin
              m_uid = sw; m_st = 'h08;
            end
      'h08: if (st) begin
              m_time = mload(cl); m_st = 'h10; m_cnt = 0;
`ifdef BOMB_STRIKES_EN
              m_strk = 0;
`endif
            end
      'h10: begin
              m_cnt++;
              tk = (m_cnt == HZ);
              if (tk) m_cnt = 0;
              if (ok) m_st = 'h20;
              else if (fl) begin
`ifdef BOMB_STRIKES_EN
                if (m_strk == 2) m_st = 'h30;
                else begin
                  m_strk++;
                  m_time = (m_time > 5) ? m_time - 5 : 0;
                end
`else
                m_st = 'h30;
`endif
              end
              else if (m_time == 0) m_st = 'h30;
              else if (tk) m_time--;
            end
      'h20: begin
              m_level++;
              if (m_level == 9) begin
                m_win = 1; m_st = 'h30;
              end else begin
                m_time = mload(cl); m_st = 'h10; m_cnt = 0;
`ifdef BOMB_STRIKES_EN
                m_strk = 0;
`endif
              end
            end
      'h30: if (st) begin
              m_st = 0; m_uid = 0; m_level = 0; m_win = 0; m_time = 0;
            end
      default: m_st = 0;
    endcase
  endtask

  initial begin
    logic [3:0] valid_ids [4];
    bit quiet;
    valid_ids[0] = 4'b1100; valid_ids[1] = 4'b0011; valid_ids[2] = 4'b1101; valid_ids[3] = 4'b0100;

    // name, login, start, ok, fail, sw, cur_level -> state, time, level, user, win
    add("login_bad",     1, 0, 0, 0, 4'b1010, 8'd0,   'h00,  0, 0,  0, 0);
    add("login_ok",      1, 0, 0, 0, 4'b1100, 8'd0,   'h08,  0, 0, 12, 0);
    add("start_lvl3",    0, 1, 0, 0, 4'b0000, 8'd3,   'h10, 45, 0, 12, 0);
    add("login_in_play", 1, 0, 0, 0, 4'b0011, 8'd3,   'h10, 45, 0, 12, 0);
    add("defuse_ok",     0, 0, 1, 0, 4'b0000, 8'd3,   'h20, 45, 0, 12, 0);
    add("reload_lvl20",  0, 0, 0, 0, 4'b0000, 8'd20,  'h10, 10, 1, 12, 0);
    add("ok_beats_fail", 0, 0, 1, 1, 4'b0000, 8'd20,  'h20, 10, 1, 12, 0);
    add("reload_lvl0",   0, 1, 0, 0, 4'b0000, 8'd0,   'h10, 60, 2, 12, 0);
    add("play_hold",     0, 0, 0, 0, 4'b0000, 8'd0,   'h10, 60, 2, 12, 0);
`ifdef BOMB_STRIKES_EN
    add("fail_strike",   0, 0, 0, 1, 4'b0000, 8'd255, 'h10, 55, 2, 12, 0);
    add("start_in_play", 0, 1, 0, 0, 4'b0000, 8'd255, 'h10, 55, 2, 12, 0);
`else
    add("fail_over",     0, 0, 0, 1, 4'b0000, 8'd255, 'h30, 60, 2, 12, 0);
    add("over_start",    0, 1, 0, 0, 4'b0000, 8'd255, 'h00,  0, 0,  0, 0);
`endif

    do_reset();
    foreach (vq[i]) begin
      cyc(vq[i].lg, vq[i].st, vq[i].ok, vq[i].fl, vq[i].sw, vq[i].cl);
      check(vq[i].name, 1'b1, vq[i].es, vq[i].et, vq[i].el, vq[i].eu, vq[i].ew);
    end

    // Countdown with CLK_HZ=4 from 10 s to expiry.
    do_reset();
    cyc(1, 0, 0, 0, 4'b0011, 8'd0);
    cyc(0, 1, 0, 0, 4'b0000, 8'd10);
    check("cd_start", 1'b1, 'h10, 10, 0, 3, 0);
    for (int k = 1; k <= 10; k++) begin
      idle(3);
      check("cd_hold", 1'b0, 'h10, 11 - k, 0, 3, 0);
      idle(1);
      check("cd_step", 1'b1, 'h10, 10 - k, 0, 3, 0);
    end
    idle(1);
    check("cd_expire", 1'b1, 'h30, 0, 0, 3, 0);
    cyc(0, 1, 0, 0, 4'b0000, 8'd0);
    check("cd_restart", 1'b1, 'h00, 0, 0, 0, 0);

    // Clear all levels to a win.
    do_reset();
    cyc(1, 0, 0, 0, 4'b1101, 8'd0);
    cyc(0, 1, 0, 0, 4'b0000, 8'd0);
    check("win_start", 1'b1, 'h10, 60, 0, 13, 0);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 1, 0, 4'b0000, 8'd0);
      check("win_done", 1'b0, 'h20, 60, i, 13, 0);
      idle(1);
      if (i < 8) check("win_next", 1'b0, 'h10, 60, i + 1, 13, 0);
      else       check("win_final", 1'b1, 'h30, 60, 9, 13, 1);
    end
    cyc(0, 1, 0, 0, 4'b0000, 8'd0);
    check("win_clear", 1'b1, 'h00, 0, 0, 0, 0);

    // Reset in the middle of play.
    cyc(1, 0, 0, 0, 4'b0100, 8'd0);
    cyc(0, 1, 0, 0, 4'b0000, 8'd1);
    check("rst_play", 1'b1, 'h10, 55, 0, 4, 0);
    idle(2);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_play", 1'b1, 'h00, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

`ifdef BOMB_STRIKES_EN
    do_reset();
    cyc(1, 0, 0, 0, 4'b1100, 8'd0);
    cyc(0, 1, 0, 0, 4'b0000, 8'd0);
    cyc(0, 0, 0, 1, 4'b0000, 8'd0);
    check("strike1", 1'b1, 'h10, 55, 0, 12, 0);
    cyc(0, 0, 0, 1, 4'b0000, 8'd0);
    check("strike2", 1'b1, 'h10, 50, 0, 12, 0);
    cyc(0, 0, 0, 1, 4'b0000, 8'd0);
    check("strike3", 1'b1, 'h30, 50, 0, 12, 0);
`endif

    // Random play against the reference model.
    do_reset();
    model_step(1'b0, 0, 0, 0, 0, 0, 0);
    quiet = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 0) quiet = 1'($urandom_range(0, 1));
      @(negedge clk);
      reset       = ($urandom_range(0, 299) != 0);
      login       = ($urandom_range(0, 3) == 0);
      user_sw     = ($urandom_range(0, 1) == 1) ? valid_ids[$urandom_range(0, 3)] : 4'($urandom_range(0, 15));
      start       = ($urandom_range(0, 5) == 0);
      defuse_ok   = quiet ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 11) == 0);
      defuse_fail = quiet ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 19) == 0);
      cur_level   = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 20));
      model_step(reset, login, start, defuse_ok, defuse_fail, int'(user_sw), int'(cur_level));
      @(posedge clk);
      #1;
      check("random", 1'b0, m_st, m_time, m_level, m_uid, m_win);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
